// File: rtl/hough_pkg.sv
// Shared types and control-word layout for the Hough sequencer.
package hough_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_VOTE   = 3'd2,
    ST_VDRAIN = 3'd3,
    ST_SCAN   = 3'd4,
    ST_SDRAIN = 3'd5,
    ST_POST   = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  // Control-word widths
  localparam int unsigned CTRL_PRE_W  = 30;
  localparam int unsigned CTRL_MEMO_W = 12;
  localparam int unsigned CTRL_FM_W   = 17;
  localparam int unsigned CTRL_POST_W = 9;

  // ctrl_pre fields
  localparam int unsigned PRE_PHI_LSB = 0;
  localparam int unsigned PRE_PHI_W   = 8;
  localparam int unsigned PRE_PHI_VLD = 8;
  localparam int unsigned PRE_LOAD    = 9;

  // ctrl_memo fields
  localparam int unsigned MEMO_RD  = 0;
  localparam int unsigned MEMO_WR  = 1;
  localparam int unsigned MEMO_CLR = 2;

  // ctrl_find_max fields
  localparam int unsigned FM_ADDR_LSB = 0;
  localparam int unsigned FM_ADDR_W   = 16;
  localparam int unsigned FM_VLD      = 16;

  // ctrl_post fields
  localparam int unsigned POST_RUN = 0;

endpackage

// File: rtl/hough_seq_ctrl_if.sv
// Edge-pixel valid/ready stream into the Hough sequencer.
interface hough_seq_ctrl_if #(
  parameter int unsigned XY_W = 16
) ();

  logic            pix_valid;
  logic            pix_ready;
  logic [XY_W-1:0] pix_x;
  logic [XY_W-1:0] pix_y;
  logic            pix_last;

  modport master (
    output pix_valid, pix_x, pix_y, pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_last,
    output pix_ready
  );

endinterface

// File: rtl/hough_sweep_cnt.sv
// Loadable up-counter shared by the address/drain sweeps and the phi sweep.
// cnt_nxt exposes the value the counter takes at the next edge so the owner
// can register outputs that line up with the count.
module hough_sweep_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W:0]   limit,
  output logic [W-1:0] cnt_nxt,
  output logic         last
);

  localparam int unsigned LW = W + 1;

  logic [W-1:0] cnt_q;

  // Next count: clear wins over increment
  always_comb begin
    cnt_nxt = cnt_q;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en) begin
      cnt_nxt = cnt_q + W'(1);
    end
  end

  // Terminal count, compared without relying on wrap
  assign last = ({1'b0, cnt_q} == (limit - LW'(1)));

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end

endmodule

// File: rtl/hough_seq_ctrl.sv
// Frame sequencer for the Hough datapath: clear, vote, scan, post, done.
// Optional build macro HOUGH_CTRL_PERF_EN adds vote-cycle and pixel counters.
module hough_seq_ctrl
  import hough_pkg::*;
#(
  parameter int unsigned N_PHI     = 180,
  parameter int unsigned ACC_DEPTH = 4096,
  parameter int unsigned VOTE_LAT  = 3,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned PHI_W     = 8,
  parameter int unsigned XY_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  hough_seq_ctrl_if.slave        pix,
  input  logic                   post_done,
  output logic [XY_W-1:0]        x,
  output logic [XY_W-1:0]        y,
  output logic                   reset_pre,
  output logic [2:0]             reset_dp,
  output logic                   post_flag,
  output logic [CTRL_PRE_W-1:0]  ctrl_pre,
  output logic [CTRL_MEMO_W-1:0] ctrl_memo,
  output logic [CTRL_FM_W-1:0]   ctrl_find_max,
  output logic [CTRL_POST_W-1:0] ctrl_post,
  output logic                   busy,
  output logic                   done
`ifdef HOUGH_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_vote_cycles,
  output logic [15:0]            perf_pix_cnt
`endif
);

  localparam int unsigned AL_W = ADDR_W + 1;
  localparam int unsigned PL_W = PHI_W + 1;

  state_e state_q, state_d;
  logic   sweep_q, sweep_d;
  logic   last_q, last_d;
  logic   pix_ready_q;
  logic   hs;

  logic              addr_clr, addr_en, addr_last;
  logic [ADDR_W:0]   addr_limit;
  logic [ADDR_W-1:0] addr_nxt;
  logic              phi_clr, phi_en, phi_last;
  logic [PHI_W-1:0]  phi_nxt;

  logic                   busy_d, done_d, ready_d, post_flag_d, reset_pre_d;
  logic [2:0]             reset_dp_d;
  logic [CTRL_PRE_W-1:0]  ctrl_pre_d;
  logic [CTRL_MEMO_W-1:0] ctrl_memo_d;
  logic [CTRL_FM_W-1:0]   ctrl_fm_d;
  logic [CTRL_POST_W-1:0] ctrl_post_d;

  // Pixel accepted this cycle; an abort discards it
  assign hs = pix.pix_valid && pix_ready_q && !abort;
  assign pix.pix_ready = pix_ready_q;

  // Address counter: CLEAR/SCAN sweep and the drain waits
  hough_sweep_cnt #(.W(ADDR_W)) u_addr_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (addr_clr),
    .en      (addr_en),
    .limit   (addr_limit),
    .cnt_nxt (addr_nxt),
    .last    (addr_last)
  );

  // Phi counter: one angle sweep per accepted pixel
  hough_sweep_cnt #(.W(PHI_W)) u_phi_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (phi_clr),
    .en      (phi_en),
    .limit   (PL_W'(N_PHI)),
    .cnt_nxt (phi_nxt),
    .last    (phi_last)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sweep_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      last_q  <= last_d;
    end
  end

  // Next state and counter control; abort overrides everything
  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    last_d     = last_q;
    addr_en    = 1'b0;
    addr_limit = AL_W'(ACC_DEPTH);
    phi_clr    = 1'b0;
    phi_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        addr_en = 1'b1;
        if (addr_last) state_d = ST_VOTE;
      end
      ST_VOTE: begin
        if (sweep_q) begin
          phi_en = 1'b1;
          if (phi_last) begin
            sweep_d = 1'b0;
            phi_clr = 1'b1;
            if (last_q) begin
              last_d  = 1'b0;
              state_d = ST_VDRAIN;
            end
          end
        end else if (hs) begin
          sweep_d = 1'b1;
          last_d  = pix.pix_last;
          phi_clr = 1'b1;
        end
      end
      ST_VDRAIN: begin
        addr_limit = AL_W'(VOTE_LAT);
        addr_en    = 1'b1;
        if (addr_last) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        addr_en = 1'b1;
        if (addr_last) state_d = ST_SDRAIN;
      end
      ST_SDRAIN: begin
        addr_limit = AL_W'(RD_LAT);
        addr_en    = 1'b1;
        if (addr_last) state_d = ST_POST;
      end
      ST_POST: begin
        if (post_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      sweep_d = 1'b0;
      last_d  = 1'b0;
      phi_clr = 1'b1;
    end
    addr_clr = abort || (state_d != state_q);
  end

  // Output decode from the upcoming state so registered outputs align with it
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    ready_d     = (state_d == ST_VOTE) && !sweep_d;
    post_flag_d = (state_d == ST_POST);
    reset_pre_d = (state_d == ST_IDLE);
    reset_dp_d  = (state_d == ST_IDLE) ? 3'b111 : 3'b000;
    ctrl_pre_d  = '0;
    ctrl_memo_d = '0;
    ctrl_fm_d   = '0;
    ctrl_post_d = '0;
    ctrl_pre_d[PRE_LOAD] = hs;
    if (sweep_d) begin
      ctrl_pre_d[PRE_PHI_VLD]                  = 1'b1;
      ctrl_pre_d[PRE_PHI_LSB +: PRE_PHI_W]     = PRE_PHI_W'(phi_nxt);
      ctrl_memo_d[MEMO_WR]                     = 1'b1;
      ctrl_memo_d[MEMO_RD]                     = 1'b1;
    end
    if (state_d == ST_CLEAR) ctrl_memo_d[MEMO_CLR] = 1'b1;
    if (state_d == ST_SCAN) begin
      ctrl_memo_d[MEMO_RD]                     = 1'b1;
      ctrl_fm_d[FM_VLD]                        = 1'b1;
      ctrl_fm_d[FM_ADDR_LSB +: FM_ADDR_W]      = FM_ADDR_W'(addr_nxt);
    end
    if (state_d == ST_POST) ctrl_post_d[POST_RUN] = 1'b1;
  end

  // Output registers and pixel latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      pix_ready_q   <= 1'b0;
      post_flag     <= 1'b0;
      reset_pre     <= 1'b1;
      reset_dp      <= 3'b111;
      ctrl_pre      <= '0;
      ctrl_memo     <= '0;
      ctrl_find_max <= '0;
      ctrl_post     <= '0;
      x             <= '0;
      y             <= '0;
    end else begin
      busy          <= busy_d;
      done          <= done_d;
      pix_ready_q   <= ready_d;
      post_flag     <= post_flag_d;
      reset_pre     <= reset_pre_d;
      reset_dp      <= reset_dp_d;
      ctrl_pre      <= ctrl_pre_d;
      ctrl_memo     <= ctrl_memo_d;
      ctrl_find_max <= ctrl_fm_d;
      ctrl_post     <= ctrl_post_d;
      if (hs) begin
        x <= pix.pix_x;
        y <= pix.pix_y;
      end
    end
  end

`ifdef HOUGH_CTRL_PERF_EN
  // Saturating performance counters, cleared by an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_vote_cycles <= '0;
      perf_pix_cnt     <= '0;
    end else if (state_q == ST_IDLE && start && !abort) begin
      perf_vote_cycles <= '0;
      perf_pix_cnt     <= '0;
    end else begin
      if ((state_q == ST_VOTE || state_q == ST_VDRAIN) && perf_vote_cycles != '1)
        perf_vote_cycles <= perf_vote_cycles + 32'd1;
      if (hs && perf_pix_cnt != '1)
        perf_pix_cnt <= perf_pix_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/hough_seq_ctrl.md
# hough_seq_ctrl

Top-level sequencer for the Hough lane-detection datapath. It accepts a start command and a stream of edge pixels, then drives the datapath control words (`ctrl_pre`, `ctrl_memo`, `ctrl_find_max`, `ctrl_post`), its sub-block resets and `post_flag`. The frame is processed in five phases: accumulator clear, voting (phi sweep per pixel), max search, post-processing and completion. It sits directly above `datapath` and replaces the hand-driven testbench sequencing.

## Interface
- `N_PHI`, 180: angle steps per pixel sweep; must satisfy `N_PHI > VOTE_LAT + 1`.
- `ACC_DEPTH`, 4096: accumulator entries that are cleared and scanned.
- `VOTE_LAT`, 3: read-modify-write latency of the accumulator path, in cycles.
- `RD_LAT`, 2: accumulator read latency into find-max, in cycles.
- `ADDR_W`, 16: accumulator address width; must satisfy `2**ADDR_W >= ACC_DEPTH`.
- `PHI_W`, 8; `XY_W`, 16.
- `clk`  in  1  system clock.
- `reset`  in  1  **asynchronous, active-low** reset.
- `start`  in  1  begin frame; sampled only in IDLE.
- `abort`  in  1  return to IDLE from any state.
- `pix_valid`, `pix_ready`  in/out  1  edge-pixel handshake.
- `pix_x`, `pix_y`  in  XY_W  edge-pixel coordinates.
- `pix_last`  in  1  qualifies the final pixel of the frame.
- `post_done`  in  1  post block has finished.
- `x`, `y`  out  XY_W  latched pixel to the datapath.
- `reset_pre`  out  1  active-high reset for the pre block.
- `reset_dp`  out  3  active-high resets: [2] post, [1] memo, [0] find-max.
- `post_flag`  out  1  high throughout POST.
- `ctrl_pre`  out  30  fields:
  - [7:0] phi index
  - [8] phi valid
  - [9] load xy
  - [29:10] zero
- `ctrl_memo`  out  12  fields:
  - [0] rd_en
  - [1] wr_en (increment)
  - [2] clear-write
  - [11:3] zero
- `ctrl_find_max`  out  17  fields:
  - [15:0] scan address
  - [16] scan valid
- `ctrl_post`  out  9  fields:
  - [0] run
  - [8:1] zero
- `busy`, `done`  out  1  status; `done` is a one-cycle pulse.

## Operation
- States: IDLE → CLEAR → VOTE → VDRAIN → SCAN → SDRAIN → POST → DONE → IDLE.
- **IDLE**
  - Held outputs: `reset_pre=1`, `reset_dp=3'b111`; all control words 0.
  - `start` moves the FSM to CLEAR.
- **CLEAR**
  - Address counter runs 0..ACC_DEPTH-1 with `ctrl_memo[2]=1`; this takes ACC_DEPTH cycles.
  - All resets are 0 from CLEAR onward.
- **VOTE**
  - `pix_ready=1` only when no sweep is active.
  - On handshake: latch `x`/`y`, pulse `ctrl_pre[9]` for one cycle, then run the sweep.
  - Sweep: phi 0..N_PHI-1 over N_PHI cycles, with `ctrl_pre[8]` and `ctrl_memo[1:0]` asserted.
  - A pixel accepted with `pix_last` moves the FSM to VDRAIN after its sweep.
- **VDRAIN**: VOTE_LAT idle cycles, so the last increments retire.
- **SCAN**: address runs 0..ACC_DEPTH-1 with `ctrl_find_max[16]=1` and `ctrl_memo[0]=1`.
- **SDRAIN**: RD_LAT cycles.
- **POST**: `post_flag=1` and `ctrl_post[0]=1` until `post_done` is sampled high.
- **DONE**: `done=1` for one cycle, then IDLE.
- `busy=1` in every state except IDLE.
- `abort` has priority over all other transitions:
  - Next state is IDLE; counters are cleared; `done` is not pulsed.
- `start` outside IDLE is ignored.
- A `pix_valid` held during CLEAR is not accepted until VOTE.
- Counters wrap-free: terminal count is compared as `== LIMIT-1`.
- No read-after-write hazard exists, because consecutive accumulator increments within a sweep target distinct phi rows and `N_PHI > VOTE_LAT+1`.

## Timing
- Reset values:
  - FSM in IDLE.
  - `busy`, `done`, `pix_ready`, `post_flag`, `x`, `y` and all control words = 0.
  - `reset_pre=1`, `reset_dp=3'b111`.
- Every output is registered.
- Cost per pixel: N_PHI+1 cycles (one handshake bubble).
- Frame latency: 1 + ACC_DEPTH + P·(N_PHI+1) + VOTE_LAT + ACC_DEPTH + RD_LAT + post cycles + 1.

## Configuration
- `HOUGH_CTRL_PERF_EN` defined:
  - Adds output `perf_vote_cycles` (32-bit), the cycles spent in VOTE+VDRAIN.
  - Adds output `perf_pix_cnt` (16-bit), the number of accepted pixels.
  - Both clear on `start` and saturate at all-ones.
- Macro undefined: neither port nor any counter logic exists.

## Structure
- Package `hough_pkg` holds:
  - the state enum;
  - the ctrl field bit-position constants;
  - control-word widths 30/12/17/9.
- One sub-module, `hough_sweep_cnt`: a loadable up-counter with `en`, `limit` and `last` outputs, used by the CLEAR/SCAN address counter and the phi counter.

## Test plan
All scenarios use N_PHI=4, ACC_DEPTH=8, VOTE_LAT=2, RD_LAT=1.
- **Reset**: reset=0 mid-frame → next edge shows all outputs at reset values and the FSM in IDLE.
- **Two-pixel frame** (start at cycle 0, `pix_valid` held):
  - CLEAR cycles 1–8; pixel 1 accepted at 9, swept phi 0–3 at 10–13.
  - Pixel 2 (last) accepted at 14 and swept at 15–18.
  - VDRAIN 19–20, SCAN 21–28, POST from 30.
  - `post_done` at 32 → `done` at 33.
- **Back-pressure**: `pix_valid` low for 5 cycles in VOTE → `pix_ready` stays 1 and no phi activity.
- **Abort**: `abort` during SCAN address 3 → IDLE next cycle, no `done` pulse, resets reasserted.
- **Start while busy**: `start` pulsed in VOTE → no restart; the frame completes normally.
- **PERF** (`HOUGH_CTRL_PERF_EN`): after the two-pixel frame → `perf_pix_cnt=2`, `perf_vote_cycles=12`.
